sipo_reg: RTL and testbench

Serial-in, parallel-out receive register; the receiving end of the team's parallel-in, serial-out shift path. Collects an LSB-first serial bit stream, qualified by a per-bit strobe, into N-bit words. Presents each completed word on a valid/ready parallel port with a one-word holding stage. Flags words lost to back-pressure.

---
 rtl/sipo_reg.sv | 120 ++++++++++++
 tb/tb_sipo_reg.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/sipo_reg.sv
// sipo_reg: serial-in, parallel-out receive register.
// Collects an LSB-first, strobe-qualified bit stream into N-bit words and
// presents each word through a one-deep valid/ready holding stage. A word
// that completes while the holding stage is full and not being drained is
// dropped and recorded in the sticky overrun flag.
module sipo_reg #(
    parameter int N = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clear,
    input  logic                 s_valid,
    input  logic                 s_data,
    output logic [N-1:0]         p_data,
    output logic                 p_valid,
    input  logic                 p_ready,
    output logic                 overrun,
    output logic [$clog2(N)-1:0] bit_cnt
);

    localparam int             CW   = $clog2(N);
    localparam logic [CW-1:0]  LAST = CW'(N - 1);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } hold_state_t;

    hold_state_t    state_q;
    hold_state_t    state_d;
    logic [N-1:0]   shift_q;
    logic [CW-1:0]  cnt_q;
    logic [N-1:0]   data_q;
    logic           overrun_q;

    // Word assembled if this edge's bit is accepted. The serial bit on a
    // clear edge is ignored, so clear also suppresses completion.
    logic [N-1:0]   shift_in;
    logic           bit_take;
    logic           complete;
    logic           load;
    logic           drop;

    assign shift_in = {s_data, shift_q[N-1:1]};
    assign bit_take = s_valid && !clear;
    assign complete = bit_take && (cnt_q == LAST);
    // A completed word is loaded when the stage is empty, or when the held
    // word is consumed on the same edge; otherwise it is lost.
    assign load     = complete && ((state_q == EMPTY) || p_ready);
    assign drop     = complete && (state_q == FULL) && !p_ready;

    // Holding-stage state register.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of block ordering.
        if (!rst_n) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Holding-stage next state: completion fills, consume without
    // completion drains; p_ready has no effect while empty.
    always_comb begin
        // NOTE: default assignment first so no path leaves state_d
        // unassigned, which would infer a latch.
        state_d = state_q;
        unique case (state_q)
            EMPTY: if (complete) state_d = FULL;
            FULL:  if (!complete && p_ready) state_d = EMPTY;
            default: state_d = EMPTY;
        endcase
    end

    // Holding-stage outputs: valid is purely a function of registered state.
    always_comb begin
        p_valid = (state_q == FULL);
    end

    // Shift register and bit counter; clear takes priority over a bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_q <= '0;
            cnt_q   <= '0;
        end else if (clear) begin
            shift_q <= '0;
            cnt_q   <= '0;
        end else if (s_valid) begin
            shift_q <= shift_in;
            cnt_q   <= (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
        end
    end

    // Parallel word register: changes only when a completed word is accepted,
    // so it is stable while held and keeps its last value after a consume.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= '0;
        end else if (load) begin
            data_q <= shift_in;
        end
    end

    // Sticky overrun flag, cleared only by reset or clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overrun_q <= 1'b0;
        end else if (clear) begin
            overrun_q <= 1'b0;
        end else if (drop) begin
            overrun_q <= 1'b1;
        end
    end

    assign p_data  = data_q;
    assign overrun = overrun_q;
    assign bit_cnt = cnt_q;

endmodule

// File: tb/tb_sipo_reg.sv
// tb_sipo_reg: directed self-checking bench for sipo_reg with N=8.
// Inputs change on the falling edge; outputs are sampled 1 ns after the
// rising edge that acts on them.
module tb_sipo_reg;

    localparam int N = 8;

    logic         clk;
    logic         rst_n;
    logic         clear;
    logic         s_valid;
    logic         s_data;
    logic [N-1:0] p_data;
    logic         p_valid;
    logic         p_ready;
    logic         overrun;
    logic [2:0]   bit_cnt;

    int total;
    int bad;

    sipo_reg #(.N(N)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (clear),
        .s_valid (s_valid),
        .s_data  (s_data),
        .p_data  (p_data),
        .p_valid (p_valid),
        .p_ready (p_ready),
        .overrun (overrun),
        .bit_cnt (bit_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One clock: apply inputs at the falling edge, return just after the
    // following rising edge.
    task automatic drive(input logic sv, input logic sd, input logic rdy, input logic clr);
        @(negedge clk);
        s_valid = sv;
        s_data  = sd;
        p_ready = rdy;
        clear   = clr;
        @(posedge clk);
        #1;
    endtask

    // Eight back-to-back bits, LSB first, with p_ready held at rdy.
    task automatic send_word(input logic [7:0] w, input logic rdy);
        for (int i = 0; i < 8; i++) drive(1'b1, w[i], rdy, 1'b0);
    endtask

    task automatic test_reset;
        rst_n = 1'b0; clear = 1'b0; s_valid = 1'b0; s_data = 1'b0; p_ready = 1'b0;
        #12;
        total++; if (p_data !== 8'h00) begin bad++; $display("FAIL reset_p_data: got %h want 00", p_data); end
        total++; if (p_valid !== 1'b0) begin bad++; $display("FAIL reset_p_valid: got %b want 0", p_valid); end
        total++; if (overrun !== 1'b0) begin bad++; $display("FAIL reset_overrun: got %b want 0", overrun); end
        total++; if (bit_cnt !== 3'd0) begin bad++; $display("FAIL reset_bit_cnt: got %0d want 0", bit_cnt); end
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        total++; if (p_valid !== 1'b0 || bit_cnt !== 3'd0) begin
            bad++; $display("FAIL reset_idle: got valid=%b cnt=%0d want valid=0 cnt=0", p_valid, bit_cnt);
        end
    endtask

    task automatic test_basic;
        logic [7:0] bits;
        bits = 8'b1010_0101;  // stream 1,0,1,0,0,1,0,1 LSB first
        for (int i = 0; i < 7; i++) drive(1'b1, bits[i], 1'b0, 1'b0);
        total++; if (p_valid !== 1'b0 || bit_cnt !== 3'd7) begin
            bad++; $display("FAIL basic_7bits: got valid=%b cnt=%0d want valid=0 cnt=7", p_valid, bit_cnt);
        end
        drive(1'b1, bits[7], 1'b0, 1'b0);
        total++; if (p_valid !== 1'b1) begin bad++; $display("FAIL basic_valid: got %b want 1", p_valid); end
        total++; if (p_data !== 8'hA5) begin bad++; $display("FAIL basic_data: got %h want a5", p_data); end
        total++; if (bit_cnt !== 3'd0) begin bad++; $display("FAIL basic_cnt_wrap: got %0d want 0", bit_cnt); end
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        total++; if (p_valid !== 1'b0 || p_data !== 8'hA5) begin
            bad++; $display("FAIL basic_consume: got valid=%b data=%h want valid=0 data=a5", p_valid, p_data);
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_gapped;
        logic [7:0] w;
        int g;
        w = 8'h3C;
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, w[i], 1'b0, 1'b0);
            if (i < 7) begin
                total++; if (p_valid !== 1'b0 || bit_cnt !== 3'(i + 1)) begin
                    bad++; $display("FAIL gap_bit%0d: got valid=%b cnt=%0d want valid=0 cnt=%0d", i, p_valid, bit_cnt, i + 1);
                end
                g = int'($urandom_range(1, 3));
                for (int k = 0; k < g; k++) begin
                    drive(1'b0, ~w[i], 1'b1, 1'b0);
                    total++; if (p_valid !== 1'b0 || bit_cnt !== 3'(i + 1)) begin
                        bad++; $display("FAIL gap_hold%0d: got valid=%b cnt=%0d want valid=0 cnt=%0d", i, p_valid, bit_cnt, i + 1);
                    end
                end
            end
        end
        total++; if (p_valid !== 1'b1 || p_data !== 8'h3C || bit_cnt !== 3'd0) begin
            bad++; $display("FAIL gap_word: got valid=%b data=%h cnt=%0d want valid=1 data=3c cnt=0", p_valid, p_data, bit_cnt);
        end
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_backpressure;
        send_word(8'h11, 1'b0);
        total++; if (p_valid !== 1'b1 || p_data !== 8'h11 || overrun !== 1'b0) begin
            bad++; $display("FAIL bp_first: got valid=%b data=%h ovr=%b want 1 11 0", p_valid, p_data, overrun);
        end
        send_word(8'h22, 1'b0);
        total++; if (p_valid !== 1'b1 || p_data !== 8'h11 || overrun !== 1'b1) begin
            bad++; $display("FAIL bp_drop: got valid=%b data=%h ovr=%b want 1 11 1", p_valid, p_data, overrun);
        end
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        total++; if (p_valid !== 1'b0 || overrun !== 1'b1) begin
            bad++; $display("FAIL bp_consume: got valid=%b ovr=%b want valid=0 ovr=1", p_valid, overrun);
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        total++; if (overrun !== 1'b1) begin bad++; $display("FAIL bp_sticky: got %b want 1", overrun); end
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        total++; if (overrun !== 1'b0 || p_data !== 8'h11) begin
            bad++; $display("FAIL bp_clear: got ovr=%b data=%h want ovr=0 data=11", overrun, p_data);
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_simultaneous;
        logic [7:0] w;
        send_word(8'h55, 1'b0);
        total++; if (p_valid !== 1'b1 || p_data !== 8'h55) begin
            bad++; $display("FAIL sim_hold: got valid=%b data=%h want 1 55", p_valid, p_data);
        end
        w = 8'hAA;
        for (int i = 0; i < 7; i++) drive(1'b1, w[i], 1'b0, 1'b0);
        total++; if (p_valid !== 1'b1 || p_data !== 8'h55) begin
            bad++; $display("FAIL sim_still_held: got valid=%b data=%h want 1 55", p_valid, p_data);
        end
        drive(1'b1, w[7], 1'b1, 1'b0);
        total++; if (p_valid !== 1'b1 || p_data !== 8'hAA || overrun !== 1'b0) begin
            bad++; $display("FAIL sim_swap: got valid=%b data=%h ovr=%b want 1 aa 0", p_valid, p_data, overrun);
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_clear_midword;
        // Still holding 0xAA: a dropped word sets overrun first.
        send_word(8'hFF, 1'b0);
        total++; if (overrun !== 1'b1 || p_data !== 8'hAA) begin
            bad++; $display("FAIL clr_setup: got ovr=%b data=%h want 1 aa", overrun, p_data);
        end
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) drive(1'b1, 1'b1, 1'b0, 1'b0);
        total++; if (bit_cnt !== 3'd3) begin bad++; $display("FAIL clr_partial: got %0d want 3", bit_cnt); end
        drive(1'b1, 1'b1, 1'b0, 1'b1);
        total++; if (bit_cnt !== 3'd0 || overrun !== 1'b0 || p_valid !== 1'b0) begin
            bad++; $display("FAIL clr_pulse: got cnt=%0d ovr=%b valid=%b want 0 0 0", bit_cnt, overrun, p_valid);
        end
        send_word(8'hC3, 1'b0);
        total++; if (p_valid !== 1'b1 || p_data !== 8'hC3 || overrun !== 1'b0 || bit_cnt !== 3'd0) begin
            bad++; $display("FAIL clr_word: got valid=%b data=%h ovr=%b cnt=%0d want 1 c3 0 0", p_valid, p_data, overrun, bit_cnt);
        end
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_back_to_back;
        send_word(8'h12, 1'b1);
        total++; if (p_valid !== 1'b1 || p_data !== 8'h12) begin
            bad++; $display("FAIL b2b_first: got valid=%b data=%h want 1 12", p_valid, p_data);
        end
        send_word(8'h34, 1'b1);
        total++; if (p_valid !== 1'b1 || p_data !== 8'h34 || overrun !== 1'b0) begin
            bad++; $display("FAIL b2b_second: got valid=%b data=%h ovr=%b want 1 34 0", p_valid, p_data, overrun);
        end
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_async_reset;
        logic [7:0] w;
        send_word(8'h7E, 1'b0);
        send_word(8'h01, 1'b0);
        w = 8'h1D;
        for (int i = 0; i < 5; i++) drive(1'b1, w[i], 1'b0, 1'b0);
        total++; if (bit_cnt !== 3'd5 || p_valid !== 1'b1 || overrun !== 1'b1 || p_data !== 8'h7E) begin
            bad++; $display("FAIL ar_setup: got cnt=%0d valid=%b ovr=%b data=%h want 5 1 1 7e", bit_cnt, p_valid, overrun, p_data);
        end
        #2;
        rst_n = 1'b0;
        #1;
        total++; if (bit_cnt !== 3'd0 || p_valid !== 1'b0 || p_data !== 8'h00 || overrun !== 1'b0) begin
            bad++; $display("FAIL ar_immediate: got cnt=%0d valid=%b data=%h ovr=%b want 0 0 00 0", bit_cnt, p_valid, p_data, overrun);
        end
        s_valid = 1'b0;
        p_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        send_word(8'h96, 1'b0);
        total++; if (p_valid !== 1'b1 || p_data !== 8'h96 || overrun !== 1'b0 || bit_cnt !== 3'd0) begin
            bad++; $display("FAIL ar_word: got valid=%b data=%h ovr=%b cnt=%0d want 1 96 0 0", p_valid, p_data, overrun, bit_cnt);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_basic();
        test_gapped();
        test_backpressure();
        test_simultaneous();
        test_clear_midword();
        test_back_to_back();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
